// File: rtl/f_pcgen_pkg.sv
// Shared widths, BTB direction-counter encodings and counter helpers for
// the fetch-stage PC generator.
package f_pcgen_pkg;

    localparam int PC_W  = 13;
    localparam int IDX_W = 4;
    localparam int TAG_W = PC_W - IDX_W;
    localparam int BTB_N = 1 << IDX_W;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = CTR_WNT;

    function automatic ctr_e ctr_inc(input ctr_e c);
        case (c)
            CTR_SNT: ctr_inc = CTR_WNT;
            CTR_WNT: ctr_inc = CTR_WT;
            default: ctr_inc = CTR_ST;
        endcase
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        case (c)
            CTR_ST:  ctr_dec = CTR_WT;
            CTR_WT:  ctr_dec = CTR_WNT;
            default: ctr_dec = CTR_SNT;
        endcase
    endfunction

endpackage

// File: rtl/f_pcgen_btb.sv
// Direct-mapped branch target buffer: combinational read on the fetch PC,
// one training write per cycle with saturating 2-bit direction counters.
import f_pcgen_pkg::*;

module f_btb (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_hit,
    output logic [PC_W-1:0] rd_target,
    output ctr_e            rd_ctr,
    input  logic            wr_valid,
    input  logic [PC_W-1:0] wr_pc,
    input  logic [PC_W-1:0] wr_target,
    input  logic            wr_taken
);

    logic            valid_q  [BTB_N];
    logic            valid_d  [BTB_N];
    logic [TAG_W-1:0] tag_q   [BTB_N];
    logic [TAG_W-1:0] tag_d   [BTB_N];
    logic [PC_W-1:0] target_q [BTB_N];
    logic [PC_W-1:0] target_d [BTB_N];
    ctr_e            ctr_q    [BTB_N];
    ctr_e            ctr_d    [BTB_N];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;

    always_comb begin
        rd_idx    = rd_pc[IDX_W-1:0];
        rd_tag    = rd_pc[PC_W-1:IDX_W];
        rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_target = target_q[rd_idx];
        rd_ctr    = ctr_q[rd_idx];
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        wr_idx   = wr_pc[IDX_W-1:0];
        wr_tag   = wr_pc[PC_W-1:IDX_W];
        wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        if (wr_valid) begin
            if (wr_taken) begin
                target_d[wr_idx] = wr_target;
                if (wr_hit) begin
                    ctr_d[wr_idx] = ctr_inc(ctr_q[wr_idx]);
                end else begin
                    // A taken miss evicts whatever aliased into this slot.
                    valid_d[wr_idx] = 1'b1;
                    tag_d[wr_idx]   = wr_tag;
                    ctr_d[wr_idx]   = CTR_WT;
                end
            end else if (wr_hit) begin
                ctr_d[wr_idx] = ctr_dec(ctr_q[wr_idx]);
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        if (!rst_n) begin
            for (int i = 0; i < BTB_N; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RST;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: rtl/f_pcgen.sv
// Fetch PC register with BTB-based next-PC prediction; execute and decode
// redirects override the prediction, stall holds the PC.
import f_pcgen_pkg::*;

module f_pcgen (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            d_redirect,
    input  logic [PC_W-1:0] d_nextpc,
    input  logic            e_redirect,
    input  logic [PC_W-1:0] e_nextpc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_predicted,
    output logic            pred_taken
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            btb_hit;
    logic [PC_W-1:0] btb_target;
    ctr_e            btb_ctr;

    f_btb u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (pc_q),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .rd_ctr    (btb_ctr),
        .wr_valid  (upd_valid),
        .wr_pc     (upd_pc),
        .wr_target (upd_target),
        .wr_taken  (upd_taken)
    );

    always_comb begin
        pc_inc       = pc_q + PC_W'(1);
        pred_taken   = btb_hit && btb_ctr[1];
        pc_predicted = pred_taken ? btb_target : pc_inc;
        // Execute holds the older instruction, so it outranks decode.
        if (e_redirect) begin
            pc_d = e_nextpc;
        end else if (d_redirect) begin
            pc_d = d_nextpc;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_predicted;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_f_pcgen.sv
// Directed self-checking bench for f_pcgen: prediction, training, redirect
// priority, stall, aliasing, wrap-around and reset.
module tb_f_pcgen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        d_redirect;
    logic [12:0] d_nextpc;
    logic        e_redirect;
    logic [12:0] e_nextpc;
    logic        upd_valid;
    logic [12:0] upd_pc;
    logic [12:0] upd_target;
    logic        upd_taken;
    logic [12:0] pc;
    logic [12:0] pc_predicted;
    logic        pred_taken;

    int checks = 0;
    int errors = 0;

    f_pcgen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .d_redirect   (d_redirect),
        .d_nextpc     (d_nextpc),
        .e_redirect   (e_redirect),
        .e_nextpc     (e_nextpc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .pc           (pc),
        .pc_predicted (pc_predicted),
        .pred_taken   (pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fetch(input string tag, input logic [12:0] e_pc,
                               input logic [12:0] e_pred, input logic e_taken);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".pc_predicted"}, 32'(pc_predicted), 32'(e_pred));
        check({tag, ".pred_taken"}, 32'(pred_taken), 32'(e_taken));
    endtask

    task automatic redirect_to(input logic [12:0] target);
        d_redirect = 1'b1;
        d_nextpc   = target;
        step();
        d_redirect = 1'b0;
    endtask

    task automatic train(input logic [12:0] p, input logic [12:0] t, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_target = t;
        upd_taken  = tk;
        step();
        upd_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        d_redirect = 1'b0; d_nextpc = '0;
        e_redirect = 1'b0; e_nextpc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;

        step();
        step();
        check_fetch("reset", 13'd0, 13'd1, 1'b0);
        rst_n = 1'b1;
        step();
        check_fetch("run1", 13'd1, 13'd2, 1'b0);
        step();
        check_fetch("run2", 13'd2, 13'd3, 1'b0);
        step();
        check_fetch("run3", 13'd3, 13'd4, 1'b0);

        // allocate 5 -> 20, ctr=10
        train(13'd5, 13'd20, 1'b1);
        check_fetch("run4", 13'd4, 13'd5, 1'b0);
        redirect_to(13'd5);
        check_fetch("hit5", 13'd5, 13'd20, 1'b1);
        step();
        check_fetch("follow20", 13'd20, 13'd21, 1'b0);

        // ctr 10 -> 01 -> 00
        train(13'd5, 13'd0, 1'b0);
        train(13'd5, 13'd0, 1'b0);
        redirect_to(13'd5);
        check_fetch("nt5", 13'd5, 13'd6, 1'b0);
        // taken update while fetching 5: ctr 00 -> 01, lookup sees old state
        train(13'd5, 13'd20, 1'b1);
        check_fetch("after_upd", 13'd6, 13'd7, 1'b0);
        redirect_to(13'd5);
        check_fetch("ctr01", 13'd5, 13'd6, 1'b0);
        // same-cycle update to the fetched index: prediction uses old ctr=01
        upd_valid = 1'b1; upd_pc = 13'd5; upd_target = 13'd20; upd_taken = 1'b1;
        #1;
        check_fetch("same_cycle", 13'd5, 13'd6, 1'b0);
        step();
        upd_valid = 1'b0;
        check_fetch("same_cycle_next", 13'd6, 13'd7, 1'b0);
        redirect_to(13'd5);
        check_fetch("ctr10", 13'd5, 13'd20, 1'b1);

        // both redirects under stall: execute wins
        stall = 1'b1;
        d_redirect = 1'b1; d_nextpc = 13'd40;
        e_redirect = 1'b1; e_nextpc = 13'd100;
        step();
        d_redirect = 1'b0; e_redirect = 1'b0;
        check("both_redirect.pc", 32'(pc), 32'd100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold.pc", 32'(pc), 32'd100);
        end
        d_redirect = 1'b1; d_nextpc = 13'd40;
        step();
        d_redirect = 1'b0;
        check("d_under_stall.pc", 32'(pc), 32'd40);
        stall = 1'b0;
        step();
        check("unstall.pc", 32'(pc), 32'd41);

        // aliasing at index 3
        train(13'd3, 13'd50, 1'b1);
        redirect_to(13'd19);
        check_fetch("alias19", 13'd19, 13'd20, 1'b0);
        train(13'd19, 13'd0, 1'b0);
        redirect_to(13'd3);
        check_fetch("hit3", 13'd3, 13'd50, 1'b1);
        step();
        check("follow50.pc", 32'(pc), 32'd50);

        // wrap-around
        redirect_to(13'h1FFF);
        check_fetch("wrap", 13'h1FFF, 13'd0, 1'b0);
        step();
        check("wrapped.pc", 32'(pc), 32'd0);

        // reset dominates a concurrent redirect and training
        rst_n = 1'b0;
        e_redirect = 1'b1; e_nextpc = 13'd7;
        upd_valid = 1'b1; upd_pc = 13'd9; upd_target = 13'd33; upd_taken = 1'b1;
        step();
        rst_n = 1'b1;
        e_redirect = 1'b0; upd_valid = 1'b0;
        check_fetch("mid_reset", 13'd0, 13'd1, 1'b0);
        redirect_to(13'd5);
        check_fetch("post_reset5", 13'd5, 13'd6, 1'b0);
        redirect_to(13'd3);
        check_fetch("post_reset3", 13'd3, 13'd4, 1'b0);
        redirect_to(13'd9);
        check_fetch("post_reset9", 13'd9, 13'd10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
